// File: rtl/scan_scheduler.sv
// rtl/scan_scheduler.sv - one radar sweep: step servo, settle, measure, send (angle, distance) pair
module scan_scheduler #(
  parameter int ANGLE_MIN      = 0,
  parameter int ANGLE_MAX      = 180,
  parameter int ANGLE_STEP     = 10,
  parameter int SETTLE_CYCLES  = 2000000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int TX_GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] servo_angle,
  output logic       sonar_measure,
  input  logic       sonar_ready,
  input  logic [7:0] sonar_distance,
  input  logic       tx_rdy,
  output logic [7:0] data,
  output logic       data_wen
);

  typedef enum logic [2:0] {IDLE, MOVE, SETTLE, TRIG, WAIT, SEND_A, SEND_D, NEXT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  angle_q, angle_d, dist_q, dist_d, data_q, data_d, guard_q, guard_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dir_down_q, dir_down_d, cont_q, cont_d, prev_ready_q, prev_ready_d;
  logic        stop_seen_q, stop_seen_d, done_q, done_d, timeout_q, timeout_d, wen_q, wen_d;

  // 9-bit arithmetic so neither leg can wrap past 0 or 255
  logic [8:0] up_sum, dn_floor;
  logic       up_ok, can_down;
  logic [7:0] up_val, dn_val;

  assign up_sum   = {1'b0, angle_q} + 9'(ANGLE_STEP);
  assign dn_floor = 9'(ANGLE_MIN) + 9'(ANGLE_STEP);
  assign up_ok    = up_sum <= 9'(ANGLE_MAX);
  assign can_down = {1'b0, angle_q} >= dn_floor;
  assign up_val   = up_ok ? up_sum[7:0] : 8'(ANGLE_MAX);
  assign dn_val   = can_down ? (angle_q - 8'(ANGLE_STEP)) : 8'(ANGLE_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      angle_q      <= 8'(ANGLE_MIN);
      dist_q       <= '0;
      data_q       <= '0;
      guard_q      <= '0;
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      cont_q       <= 1'b0;
      prev_ready_q <= 1'b0;
      stop_seen_q  <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      angle_q      <= angle_d;
      dist_q       <= dist_d;
      data_q       <= data_d;
      guard_q      <= guard_d;
      cnt_q        <= cnt_d;
      dir_down_q   <= dir_down_d;
      cont_q       <= cont_d;
      prev_ready_q <= prev_ready_d;
      stop_seen_q  <= stop_seen_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      wen_q        <= wen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    angle_d      = angle_q;
    dist_d       = dist_q;
    data_d       = data_q;
    guard_d      = (guard_q != 8'd0) ? guard_q - 8'd1 : 8'd0;
    cnt_d        = cnt_q;
    dir_down_d   = dir_down_q;
    cont_d       = cont_q;
    prev_ready_d = prev_ready_q;
    stop_seen_d  = stop_seen_q | (stop & (state_q != IDLE));
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    wen_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d     = MOVE;
          cont_d      = continuous;
          dir_down_d  = 1'b0;
          angle_d     = 8'(ANGLE_MIN);
          stop_seen_d = 1'b0;
        end
      end
      MOVE: begin
        cnt_d   = 32'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 32'd0) state_d = TRIG;
        else                cnt_d   = cnt_q - 32'd1;
      end
      TRIG: begin
        prev_ready_d = sonar_ready;
        cnt_d        = 32'(TIMEOUT_CYCLES - 1);
        state_d      = WAIT;
      end
      WAIT: begin
        // only a fresh rising edge counts; a level left over from TRIG is stale
        prev_ready_d = sonar_ready;
        if (!prev_ready_q && sonar_ready) begin
          dist_d  = sonar_distance;
          state_d = SEND_A;
        end else if (cnt_q == 32'd0) begin
          timeout_d = 1'b1;
          dist_d    = 8'hFF;
          state_d   = SEND_A;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      SEND_A: begin
        if (guard_q == 8'd0 && tx_rdy) begin
          wen_d   = 1'b1;
          data_d  = angle_q;
          guard_d = 8'(TX_GUARD);
          state_d = SEND_D;
        end
      end
      SEND_D: begin
        if (guard_q == 8'd0 && tx_rdy) begin
          wen_d   = 1'b1;
          data_d  = dist_q;
          guard_d = 8'(TX_GUARD);
          state_d = NEXT;
        end
      end
      NEXT: begin
        stop_seen_d = 1'b0;
        if (stop_seen_q || stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!dir_down_q) begin
          if (up_ok) begin
            angle_d = up_sum[7:0];
            state_d = MOVE;
          end else if (!cont_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            dir_down_d = 1'b1;
            angle_d    = dn_val;
            state_d    = MOVE;
          end
        end else begin
          if (can_down) begin
            angle_d = dn_val;
            state_d = MOVE;
          end else if (!cont_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            dir_down_d = 1'b0;
            angle_d    = up_val;
            state_d    = MOVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign servo_angle   = angle_q;
  assign sonar_measure = (state_q == TRIG);
  assign data          = data_q;
  assign data_wen      = wen_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// tb/tb_scan_scheduler.sv - directed bench for scan_scheduler with sonar and byte monitor models
module tb_scan_scheduler;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0, tx_rdy = 1'b1;
  logic       sonar_ready = 1'b0;
  logic [7:0] sonar_distance = 8'd0;
  logic       busy, done, timeout, sonar_measure, data_wen;
  logic [7:0] servo_angle, data;

  int checks = 0, errors = 0, cyc = 0;
  int sonar_mode = 0;  // 0 normal, 1 never ready, 2 ready held high (stale)
  logic [7:0] bytes[$];
  int to_cyc[$];
  int meas_gap[$];
  int done_cnt = 0, meas_cnt = 0, last_move = 0, sc = 0;
  logic [7:0] prev_angle = 8'd0;
  logic prev_busy = 1'b0, armed = 1'b0;

  scan_scheduler #(
    .ANGLE_MIN(0), .ANGLE_MAX(30), .ANGLE_STEP(10),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50), .TX_GUARD(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .busy(busy), .done(done), .timeout(timeout), .servo_angle(servo_angle),
    .sonar_measure(sonar_measure), .sonar_ready(sonar_ready), .sonar_distance(sonar_distance),
    .tx_rdy(tx_rdy), .data(data), .data_wen(data_wen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor and sonar model, both on the falling edge
  always @(negedge clk) begin
    if (busy && (!prev_busy || servo_angle != prev_angle)) last_move = cyc;
    prev_busy  = busy;
    prev_angle = servo_angle;
    if (data_wen) bytes.push_back(data);
    if (timeout) to_cyc.push_back(cyc);
    if (done) done_cnt++;
    if (sonar_measure) begin
      meas_cnt++;
      meas_gap.push_back(cyc - last_move);
      armed = 1'b1;
      if (sonar_mode == 2) begin
        sc = 10;
        sonar_ready = 1'b1;
        sonar_distance = 8'h55;
      end else begin
        sc = 5;
        sonar_ready = 1'b0;
      end
    end else if (armed && sonar_mode != 1) begin
      sc--;
      if (sonar_mode == 2 && sc == 5) sonar_ready = 1'b0;
      if (sc == 0) begin
        sonar_ready = 1'b1;
        sonar_distance = servo_angle + 8'd1;
        armed = 1'b0;
      end
    end else if (sonar_mode == 2 && !armed) begin
      sonar_ready = 1'b1;
    end
  end

  task automatic pulse_start(input logic cont);
    @(negedge clk);
    continuous = cont;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic expired);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    expired = (done_cnt == d0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", timeout); end
    checks++; if (sonar_measure !== 1'b0) begin errors++; $display("FAIL reset_measure got %0b want 0", sonar_measure); end
    checks++; if (data_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", data_wen); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (servo_angle !== 8'h00) begin errors++; $display("FAIL reset_angle got %h want 00", servo_angle); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_stop;
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_stop busy got %0b want 0", busy); end
  endtask

  task automatic test_single_sweep;
    logic [7:0] ex [8] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h14, 8'h15, 8'h1E, 8'h1F};
    int base = bytes.size();
    int m0 = meas_cnt, g0 = meas_gap.size(), d0 = done_cnt;
    logic expired;
    sonar_mode = 0;
    pulse_start(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_start got %0b want 1", busy); end
    wait_done(1000, expired);
    checks++; if (expired) begin errors++; $display("FAIL single_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 8) begin errors++; $display("FAIL single_count got %0d want 8", bytes.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL single_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
    checks++; if (meas_cnt - m0 != 4) begin errors++; $display("FAIL single_measures got %0d want 4", meas_cnt - m0); end
    for (int i = g0; i < meas_gap.size(); i++) begin
      checks++; if (meas_gap[i] < 4) begin errors++; $display("FAIL single_settle_gap got %0d want >=4", meas_gap[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %0b want 0", busy); end
    checks++; if (servo_angle !== 8'h1E) begin errors++; $display("FAIL single_angle_end got %h want 1e", servo_angle); end
  endtask

  task automatic test_timeout;
    logic [7:0] ex [8] = '{8'h00, 8'hFF, 8'h0A, 8'hFF, 8'h14, 8'hFF, 8'h1E, 8'hFF};
    int base = bytes.size();
    int t0 = to_cyc.size();
    logic expired;
    sonar_mode = 1;
    pulse_start(1'b0);
    wait_done(2000, expired);
    checks++; if (expired) begin errors++; $display("FAIL tmo_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 8) begin errors++; $display("FAIL tmo_count got %0d want 8", bytes.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL tmo_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL tmo_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
    checks++; if (to_cyc.size() - t0 != 4) begin errors++; $display("FAIL tmo_pulses got %0d want 4", to_cyc.size() - t0); end
    for (int i = t0 + 1; i < to_cyc.size(); i++) begin
      checks++; if (to_cyc[i] - to_cyc[i - 1] < 50) begin errors++; $display("FAIL tmo_spacing got %0d want >=50", to_cyc[i] - to_cyc[i - 1]); end
    end
    sonar_mode = 0;
  endtask

  task automatic test_continuous_stop;
    logic [7:0] ex [10] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h14, 8'h15, 8'h1E, 8'h1F, 8'h14, 8'h15};
    int base = bytes.size();
    int n = 0;
    int b1;
    logic expired;
    sonar_mode = 0;
    pulse_start(1'b1);
    while (!(busy && servo_angle == 8'h14 && bytes.size() - base == 8) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 1000) begin errors++; $display("FAIL cont_reach_down20 got expired want angle 14"); end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    continuous = 1'b0;
    wait_done(500, expired);
    checks++; if (expired) begin errors++; $display("FAIL cont_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 10) begin errors++; $display("FAIL cont_count got %0d want 10", bytes.size() - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL cont_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL cont_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
    b1 = bytes.size();
    repeat (60) @(negedge clk);
    checks++; if (bytes.size() != b1) begin errors++; $display("FAIL cont_after_stop got %0d extra want 0", bytes.size() - b1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] ex [8] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h14, 8'h15, 8'h1E, 8'h1F};
    int base = bytes.size();
    logic expired;
    tx_rdy = 1'b0;
    pulse_start(1'b0);
    repeat (100) @(negedge clk);
    checks++; if (bytes.size() != base) begin errors++; $display("FAIL bp_no_write got %0d want 0", bytes.size() - base); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_hold got %0b want 1", busy); end
    tx_rdy = 1'b1;
    wait_done(1000, expired);
    checks++; if (expired) begin errors++; $display("FAIL bp_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 8) begin errors++; $display("FAIL bp_count got %0d want 8", bytes.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL bp_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ex [8] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h14, 8'h15, 8'h1E, 8'h1F};
    int m0 = meas_cnt;
    int n = 0;
    int b1, base;
    logic expired;
    sonar_mode = 0;
    pulse_start(1'b0);
    while (meas_cnt - m0 < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 500) begin errors++; $display("FAIL rstmid_reach_wait got expired want second measure"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    checks++; if (servo_angle !== 8'h00) begin errors++; $display("FAIL rstmid_angle got %h want 00", servo_angle); end
    checks++; if (data_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %0b want 0", data_wen); end
    rst = 1'b0;
    b1 = bytes.size();
    repeat (40) @(negedge clk);
    checks++; if (bytes.size() != b1) begin errors++; $display("FAIL rstmid_no_bytes got %0d want 0", bytes.size() - b1); end
    base = bytes.size();
    pulse_start(1'b0);
    wait_done(1000, expired);
    checks++; if (expired) begin errors++; $display("FAIL rstmid_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 8) begin errors++; $display("FAIL rstmid_count got %0d want 8", bytes.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL rstmid_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
  endtask

  task automatic test_stale_ready;
    logic [7:0] ex [8] = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h14, 8'h15, 8'h1E, 8'h1F};
    int base = bytes.size();
    logic expired;
    sonar_mode = 2;
    repeat (2) @(negedge clk);
    pulse_start(1'b0);
    wait_done(1000, expired);
    checks++; if (expired) begin errors++; $display("FAIL stale_done_timeout got expired want done"); end
    checks++; if (bytes.size() - base != 8) begin errors++; $display("FAIL stale_count got %0d want 8", bytes.size() - base); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base + i >= bytes.size()) begin errors++; $display("FAIL stale_byte%0d got none want %h", i, ex[i]); end
      else if (bytes[base + i] !== ex[i]) begin errors++; $display("FAIL stale_byte%0d got %h want %h", i, bytes[base + i], ex[i]); end
    end
    sonar_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_stop();
    test_single_sweep();
    test_timeout();
    test_continuous_stop();
    test_backpressure();
    test_reset_mid();
    test_stale_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
